// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path constants: queue depth, reset PC, bus widths and pointer sizing.
// Decode and hazard logic import these so every stage agrees on the sizes.
package fetch_queue_pkg;

  localparam int          FQ_DEPTH    = 4;
  localparam int          FQ_AW       = 32;
  localparam int          FQ_DW       = 32;
  localparam logic [31:0] FQ_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] FQ_PC_STEP  = 32'd4;

  // Pointer width for a power-of-two queue; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fq_store.sv
// Entry storage: DEPTH x EW registers, one write port, one asynchronous read port.
// Zero-cycle read latency; no backpressure here, the parent gates the write enable.
module fq_store
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PW    = ptr_w(DEPTH),
  parameter int EW    = FQ_AW + FQ_DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  // Contents are qualified by the parent's count, so no reset is needed.
  logic [EW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: pushes {pc, instr} from a combinational imem, pops toward decode.
// Latency: one cycle push-to-head; backpressure: fetch stalls (pc holds) when full with no pop.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int            DEPTH    = FQ_DEPTH,
  parameter int            AW       = FQ_AW,
  parameter int            DW       = FQ_DW,
  parameter logic [AW-1:0] RESET_PC = AW'(FQ_RESET_PC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_en,
  input  logic                    redirect,
  input  logic [AW-1:0]           redirect_pc,
  output logic [AW-1:0]           imem_addr,
  input  logic [DW-1:0]           imem_rdata,
  output logic                    out_valid,
  output logic [DW-1:0]           out_instr,
  output logic [AW-1:0]           out_pc,
  input  logic                    out_ready,
  output logic [ptr_w(DEPTH):0]   count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + DW;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [AW-1:0] fetch_pc;
  logic          pop;
  logic          push;
  logic [EW-1:0] head_dat;

  assign out_valid = (count != '0);
  assign imem_addr = fetch_pc;

  // Redirect suppresses both sides; a full queue still accepts a push when it pops.
  assign pop  = out_valid & out_ready & ~redirect;
  assign push = fetch_en & ~redirect & ((count < FULL) | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (pop) head <= head + PW'(1);
      if (push) begin
        tail     <= tail + PW'(1);
        fetch_pc <= fetch_pc + AW'(FQ_PC_STEP);
      end
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  fq_store #(
    .DEPTH (DEPTH),
    .PW    (PW),
    .EW    (EW)
  ) u_store (
    .clk   (clk),
    .we    (push),
    .waddr (tail),
    .wdata ({fetch_pc, imem_rdata}),
    .raddr (head),
    .rdata (head_dat)
  );

  assign out_pc    = head_dat[EW-1:DW];
  assign out_instr = head_dat[DW-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboarded bench for fetch_queue: directed scenarios then random traffic against a queue model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic [2:0]  count;

  fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ready   (out_ready),
    .count       (count)
  );

  // Combinational instruction memory: content is a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hFFFF_FFFF;
  endfunction
  assign imem_rdata = mem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        exp_q[$];
  int          m_cnt;
  logic [31:0] m_pc;
  int          checks;
  int          failures;
  bit          mon_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: applies the current inputs for the coming clock edge.
  task automatic model_step();
    bit p;
    bit q;
    if (redirect) begin
      exp_q.delete();
      m_cnt = 0;
      m_pc  = redirect_pc;
    end else begin
      p = (m_cnt > 0) && out_ready;
      q = fetch_en && ((m_cnt < DEPTH) || p);
      if (q) begin
        exp_q.push_back('{m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
      m_cnt = m_cnt + int'(q) - int'(p);
    end
  endtask

  // Monitor: compares visible state and the head entry, retires accepted entries.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("count", 32'(count), 32'(m_cnt));
      chk("imem_addr", imem_addr, m_pc);
      chk("out_valid", 32'(out_valid), 32'(m_cnt != 0));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("head_unexpected", 32'(out_valid), 32'd0);
        end else begin
          chk("out_pc", out_pc, exp_q[0].pc);
          chk("out_instr", out_instr, exp_q[0].instr);
          if (out_ready && !redirect) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cycle(input logic fe, input logic rd, input logic [31:0] rpc, input logic rdy);
    fetch_en    = fe;
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    fetch_en  = 1'b1;
    redirect  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_imem_addr", imem_addr, RST_PC);
    chk("arst_count", 32'(count), 32'd0);
    exp_q.delete();
    m_cnt = 0;
    m_pc  = RST_PC;
    #1;
    rst = 1'b0;
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    mon_en      = 1'b0;
    m_cnt       = 0;
    m_pc        = RST_PC;
    rst         = 1'b1;
    fetch_en    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_imem_addr", imem_addr, RST_PC);
    #4;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Fill with decode stalled.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_imem_addr", imem_addr, 32'h0000_3010);
    chk("fill_out_pc", out_pc, 32'h0000_3000);
    chk("fill_out_instr", out_instr, 32'hFFFF_CFFF);

    // Full and streaming: one in, one out every cycle.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b1);
      chk("stream_count", 32'(count), 32'd4);
      chk("stream_out_pc", out_pc, 32'(32'h0000_3004 + 4 * i));
    end

    // Drop to three entries, then redirect while ready and with room.
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("three_count", 32'(count), 32'd3);
    cycle(1'b1, 1'b1, 32'h0000_3400, 1'b1);
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_out_valid", 32'(out_valid), 32'd0);
    chk("redir_imem_addr", imem_addr, 32'h0000_3400);
    cycle(1'b1, 1'b0, '0, 1'b0);
    chk("redir_out_pc", out_pc, 32'h0000_3400);

    // Refill, then drain with fetch disabled.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    chk("refill_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      chk("drain_imem_addr", imem_addr, 32'h0000_3410);
    end
    chk("drain_count", 32'(count), 32'd0);

    // Back-to-back redirects: the later target wins.
    cycle(1'b1, 1'b1, 32'h0000_5000, 1'b0);
    cycle(1'b1, 1'b1, 32'h0000_6000, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    chk("redir2_out_pc", out_pc, 32'h0000_6000);

    // Two entries, then asynchronous reset between edges.
    cycle(1'b1, 1'b0, '0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd2);
    reset_pulse();
    chk("post_rst_out_pc", out_pc, RST_PC);
    chk("post_rst_count", 32'(count), 32'd1);

    // Random traffic, including redirects near the top of the address space.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4))
                                        : ($urandom & 32'h0000_FFFC);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rpc,
            $urandom_range(0, 1) == 1);
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
